bm_expr_operand_gen: RTL and testbench

BM_EXPR_OPERAND_GEN -- requirements
Module: bm_expr_operand_gen

---
 rtl/bm_expr_operand_gen.sv | 120 ++++++++++++
 tb/tb_bm_expr_operand_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bm_expr_operand_gen.sv
// rtl/bm_expr_operand_gen.sv - LFSR-driven operand burst generator for the expression stage.
// Optional seed loading is enabled by defining EXPR_OPGEN_SEED_LOAD_EN.
module bm_expr_operand_gen #(
   parameter int BITS = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [7:0]      burst_len,
   input  logic            stall,
`ifdef EXPR_OPGEN_SEED_LOAD_EN
   input  logic            seed_load,
   input  logic [BITS-1:0] seed,
`endif
   output logic [BITS-1:0] number_in_1,
   output logic [BITS-1:0] number_in_2,
   output logic [BITS-2:0] number_in_3,
   output logic [BITS-1:0] land_1,
   output logic [BITS-1:0] lor_1,
   output logic            land_2,
   output logic            lor_2,
   output logic            op_valid,
   output logic            busy,
   output logic            done,
   output logic [7:0]      op_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [BITS-1:0] TAPS      = 'h80200003;
   localparam logic [BITS-1:0] LFSR_INIT = 'h1;

   state_t          state;
   logic [BITS-1:0] lfsr;
   logic [BITS-1:0] lfsr_next;
   logic [7:0]      len_q;
   logic            last_set;

   assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
   // A latched length of 0 compares equal after 256 sets because op_count wraps.
   assign last_set  = (op_count + 8'd1) == len_q;

`ifdef EXPR_OPGEN_SEED_LOAD_EN
   logic [BITS-1:0] seed_eff;
   assign seed_eff = (seed == '0) ? LFSR_INIT : seed;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         lfsr        <= LFSR_INIT;
         len_q       <= 8'd0;
         number_in_1 <= '0;
         number_in_2 <= '0;
         number_in_3 <= '0;
         land_1      <= '0;
         lor_1       <= '0;
         land_2      <= 1'b0;
         lor_2       <= 1'b0;
         op_valid    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         op_count    <= 8'd0;
      end else begin
         op_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               busy <= start;
`ifdef EXPR_OPGEN_SEED_LOAD_EN
               if (seed_load) begin
                  lfsr <= seed_eff;
               end
`endif
               if (start) begin
                  len_q    <= burst_len;
                  op_count <= 8'd0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (stall) begin
                  state <= S_HOLD;
               end else begin
                  lfsr        <= lfsr_next;
                  number_in_1 <= lfsr_next;
                  number_in_2 <= {lfsr_next[BITS/2-1:0], lfsr_next[BITS-1:BITS/2]};
                  number_in_3 <= lfsr_next[BITS-2:0] ^ lfsr_next[BITS-1:1];
                  land_1      <= lfsr_next;
                  // Every fourth set makes lor_1 equal land_1 to hit equality compares.
                  lor_1       <= (op_count[1:0] == 2'b11) ? lfsr_next : ~lfsr_next;
                  land_2      <= lfsr_next[0];
                  lor_2       <= lfsr_next[BITS-1];
                  op_valid    <= 1'b1;
                  op_count    <= op_count + 8'd1;
                  if (last_set) begin
                     state <= S_DONE;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  state <= S_RUN;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bm_expr_operand_gen.sv
// tb/tb_bm_expr_operand_gen.sv - self-checking bench for bm_expr_operand_gen.
module tb_bm_expr_operand_gen;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  burst_len;
   logic        stall;
`ifdef EXPR_OPGEN_SEED_LOAD_EN
   logic        seed_load;
   logic [31:0] seed;
`endif
   logic [31:0] number_in_1, number_in_2, land_1, lor_1;
   logic [30:0] number_in_3;
   logic        land_2, lor_2, op_valid, busy, done;
   logic [7:0]  op_count;

   bm_expr_operand_gen #(.BITS(32)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .start(start),
      .burst_len(burst_len),
      .stall(stall),
`ifdef EXPR_OPGEN_SEED_LOAD_EN
      .seed_load(seed_load),
      .seed(seed),
`endif
      .number_in_1(number_in_1),
      .number_in_2(number_in_2),
      .number_in_3(number_in_3),
      .land_1(land_1),
      .lor_1(lor_1),
      .land_2(land_2),
      .lor_2(lor_2),
      .op_valid(op_valid),
      .busy(busy),
      .done(done),
      .op_count(op_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]  m_lfsr;
   logic [159:0] prev_ops;
   logic [31:0]  first_n1, second_n1;

   typedef struct {
      logic [7:0] len;
      int         stall_pct;
      int         exp_sets;
      bit         noise;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ ((l & 32'h1) != 0 ? 32'h80200003 : 32'h0);
   endfunction

   function automatic logic [159:0] pack_dut();
      return {number_in_1, number_in_2, 1'b0, number_in_3, land_1, lor_1, 30'd0, land_2, lor_2};
   endfunction

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ops"}, 32'(pack_dut() != '0), 32'd0);
      check({tag, "_op_valid"}, 32'(op_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_op_count"}, 32'(op_count), 32'd0);
   endtask

   // fixed_stall: hold stall for 3 edges right after the 2nd set.
   task automatic run_burst(input logic [7:0] len, input int stall_pct, input int exp_sets,
                            input bit noise, input bit fixed_stall);
      int sets, dones, last_valid, stall_left, idx;
      bit s_edge;
      logic [31:0] l, e_lor1;
      logic [159:0] e_ops;
      burst_len = len;
      start     = 1'b1;
      stall     = 1'b0;
      tick();
      start = 1'b0;
`ifdef EXPR_OPGEN_SEED_LOAD_EN
      seed_load = 1'b0;
`endif
      check("busy_after_start", 32'(busy), 32'd1);
      check("no_valid_on_start_edge", 32'(op_valid), 32'd0);
      sets = 0; dones = 0; last_valid = -10; stall_left = 0;
      for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
         if (fixed_stall) begin
            stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
         end else begin
            stall = ($urandom_range(99) < stall_pct);
         end
         if (noise) begin
            start     = $urandom_range(1);
            burst_len = 8'($urandom);
         end
         s_edge = stall;
         tick();
         if (s_edge) check("valid_while_stalled", 32'(op_valid), 32'd0);
         if (op_valid) begin
            idx    = sets;
            m_lfsr = lfsr_step(m_lfsr);
            l      = m_lfsr;
            e_lor1 = (idx % 4 == 3) ? l : ~l;
            e_ops  = {l, l[15:0], l[31:16], 1'b0, l[30:0] ^ l[31:1], l, e_lor1, 30'd0, l[0], l[31]};
            check("number_in_1", number_in_1, l);
            check("number_in_2", number_in_2, {l[15:0], l[31:16]});
            check("number_in_3", 32'(number_in_3), 32'(l[30:0] ^ l[31:1]));
            check("land_1", land_1, l);
            check("lor_1", lor_1, e_lor1);
            check("land_lor_2", {30'd0, land_2, lor_2}, {30'd0, l[0], l[31]});
            check("op_count", 32'(op_count), (idx + 1) % 256);
            if (idx == 0) first_n1 = number_in_1;
            if (idx == 1) second_n1 = number_in_1;
            if (idx == 0 && stall_pct == 0 && !fixed_stall) check("first_set_latency", cyc, 0);
            prev_ops   = e_ops;
            sets++;
            last_valid = cyc;
            if (fixed_stall && sets == 2) stall_left = 3;
         end else begin
            check("frozen_operands", 32'(pack_dut() != prev_ops), 32'd0);
         end
         if (done) begin
            dones++;
            check("done_after_last_set", cyc, last_valid + 1);
            check("busy_during_done", 32'(busy), 32'd1);
         end
      end
      start = 1'b0;
      stall = 1'b0;
      check("burst_completed", dones, 1);
      check("sets_issued", sets, exp_sets);
      check("final_op_count", 32'(op_count), exp_sets % 256);
      tick();
      check("done_single_pulse", 32'(done), 32'd0);
      check("busy_cleared", 32'(busy), 32'd0);
      check("valid_after_burst", 32'(op_valid), 32'd0);
   endtask

   task automatic apply_reset();
      #2 reset_n = 1'b0;
      #1;
      check_zero_outputs("reset");
      tick();
      #2 reset_n = 1'b1;
      m_lfsr   = 32'h1;
      prev_ops = '0;
   endtask

   initial begin
      int sets;
      reset_n = 1'b0; start = 1'b0; burst_len = 8'd0; stall = 1'b0;
`ifdef EXPR_OPGEN_SEED_LOAD_EN
      seed_load = 1'b0; seed = 32'd0;
`endif
      vecs[0] = '{len: 8'd3,   stall_pct: 0,  exp_sets: 3,   noise: 1'b0};
      vecs[1] = '{len: 8'd5,   stall_pct: 40, exp_sets: 5,   noise: 1'b0};
      vecs[2] = '{len: 8'd0,   stall_pct: 0,  exp_sets: 256, noise: 1'b0};
      vecs[3] = '{len: 8'd1,   stall_pct: 30, exp_sets: 1,   noise: 1'b1};
      vecs[4] = '{len: 8'd12,  stall_pct: 25, exp_sets: 12,  noise: 1'b1};
      vecs[5] = '{len: 8'd255, stall_pct: 10, exp_sets: 255, noise: 1'b0};

      repeat (2) tick();
      check_zero_outputs("reset_init");
      #2 reset_n = 1'b1;
      m_lfsr = 32'h1; prev_ops = '0;
      tick();
      check_zero_outputs("idle_after_reset");

      run_burst(8'd2, 0, 2, 1'b0, 1'b0);
      check("first_n1_const", first_n1, 32'h80200003);
      check("second_n1_const", second_n1, 32'hC0300002);

      run_burst(8'd8, 0, 8, 1'b0, 1'b1);

      foreach (vecs[i]) run_burst(vecs[i].len, vecs[i].stall_pct, vecs[i].exp_sets, vecs[i].noise, 1'b0);

      burst_len = 8'd10; start = 1'b1;
      tick();
      start = 1'b0;
      sets = 0;
      for (int c = 0; c < 50 && sets < 3; c++) begin
         tick();
         if (op_valid) sets++;
      end
      check("sets_before_reset", sets, 3);
      #2 reset_n = 1'b0;
      #1;
      check_zero_outputs("midburst_reset");
      repeat (3) begin
         tick();
         check("no_done_in_reset", 32'(done), 32'd0);
      end
      #2 reset_n = 1'b1;
      m_lfsr = 32'h1; prev_ops = '0;
      run_burst(8'd1, 0, 1, 1'b0, 1'b0);
      check("restart_first_n1", first_n1, 32'h80200003);

`ifdef EXPR_OPGEN_SEED_LOAD_EN
      apply_reset();
      seed = 32'd0; seed_load = 1'b1;
      m_lfsr = 32'h1;
      run_burst(8'd2, 0, 2, 1'b0, 1'b0);
      check("seed0_first_n1", first_n1, 32'h80200003);
      seed = $urandom | 32'h1; seed_load = 1'b1;
      m_lfsr = seed;
      run_burst(8'd4, 20, 4, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
